// File: rtl/ray_scanner_if.sv
// ============================================================================
// Module      : ray_scanner_if
// Description : Request/result and board-RAM read signals for ray_scanner.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ray_scanner_if;
    logic       start;
    logic       player;
    logic [6:0] s_addr_in;
    logic [2:0] dir_in;
    logic [1:0] data_in;
    logic [6:0] addr_out;
    logic       ctrl_mem;
    logic       done;
    logic       valid;
    logic [2:0] count;
    logic [4:0] step_o;

    modport master (
        output start, player, s_addr_in, dir_in, data_in,
        input  addr_out, ctrl_mem, done, valid, count, step_o
    );

    modport slave (
        input  start, player, s_addr_in, dir_in, data_in,
        output addr_out, ctrl_mem, done, valid, count, step_o
    );
endinterface

`default_nettype wire

// File: rtl/ray_scanner.sv
// ============================================================================
// Module      : ray_scanner
// Description : Walks the board RAM along one direction from a candidate
//               square and reports whether that direction flips discs.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ray_scanner (
    input  logic          clock,
    input  logic          reset,
    ray_scanner_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_STEP = 3'd1,
        S_WAIT = 3'd2,
        S_EVAL = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t     r_state, w_state;
    logic [2:0] r_row, w_row;
    logic [2:0] r_col, w_col;
    logic [2:0] r_count, w_count;
    logic [2:0] r_dir, w_dir;
    logic       r_player, w_player;
    logic [6:0] r_addr, w_addr;
    logic       r_ctrl, w_ctrl;
    logic       r_done, w_done;
    logic       r_valid, w_valid;
    logic [4:0] r_step, w_step;

    logic [3:0] w_sum_row;
    logic [3:0] w_sum_col;
    logic       w_off_board;
    logic [1:0] w_opp;
    logic [1:0] w_own;

    // Row/column deltas as 4-bit two's complement (-1, 0, +1)
    function automatic logic [3:0] dir_dr(input logic [2:0] d);
        case (d)
            3'd0, 3'd1, 3'd7: dir_dr = 4'b1111;
            3'd3, 3'd4, 3'd5: dir_dr = 4'b0001;
            default:          dir_dr = 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] dir_dc(input logic [2:0] d);
        case (d)
            3'd1, 3'd2, 3'd3: dir_dc = 4'b0001;
            3'd5, 3'd6, 3'd7: dir_dc = 4'b1111;
            default:          dir_dc = 4'b0000;
        endcase
    endfunction

    function automatic logic [4:0] dir_step(input logic [2:0] d);
        logic [3:0] dr;
        logic [3:0] dc;
        dr = dir_dr(d);
        dc = dir_dc(d);
        dir_step = {dr[1:0], 3'b000} + {dc[3], dc};
    endfunction

    // Coordinates leaving 0..7 (i.e. -1 or 8) always set bit 3
    assign w_sum_row   = {1'b0, r_row} + dir_dr(r_dir);
    assign w_sum_col   = {1'b0, r_col} + dir_dc(r_dir);
    assign w_off_board = w_sum_row[3] | w_sum_col[3];
    assign w_opp       = r_player ? 2'b01 : 2'b10;
    assign w_own       = r_player ? 2'b10 : 2'b01;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_row    <= 3'd0;
            r_col    <= 3'd0;
            r_count  <= 3'd0;
            r_dir    <= 3'd0;
            r_player <= 1'b0;
            r_addr   <= 7'd0;
            r_ctrl   <= 1'b0;
            r_done   <= 1'b0;
            r_valid  <= 1'b0;
            r_step   <= 5'd0;
        end else begin
            r_state  <= w_state;
            r_row    <= w_row;
            r_col    <= w_col;
            r_count  <= w_count;
            r_dir    <= w_dir;
            r_player <= w_player;
            r_addr   <= w_addr;
            r_ctrl   <= w_ctrl;
            r_done   <= w_done;
            r_valid  <= w_valid;
            r_step   <= w_step;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_row    = r_row;
        w_col    = r_col;
        w_count  = r_count;
        w_dir    = r_dir;
        w_player = r_player;
        w_addr   = r_addr;
        w_ctrl   = r_ctrl;
        w_done   = 1'b0;
        w_valid  = r_valid;
        w_step   = r_step;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_player = bus.player;
                    w_dir    = bus.dir_in;
                    w_row    = bus.s_addr_in[5:3];
                    w_col    = bus.s_addr_in[2:0];
                    w_step   = dir_step(bus.dir_in);
                    w_valid  = 1'b0;
                    w_count  = 3'd0;
                    w_state  = bus.s_addr_in[6] ? S_DONE : S_STEP;
                end
            end
            S_STEP: begin
                if (w_off_board) begin
                    w_valid = 1'b0;
                    w_state = S_DONE;
                end else begin
                    w_row   = w_sum_row[2:0];
                    w_col   = w_sum_col[2:0];
                    w_addr  = {1'b0, w_sum_row[2:0], w_sum_col[2:0]};
                    w_ctrl  = 1'b1;
                    w_state = S_WAIT;
                end
            end
            S_WAIT: begin
                w_state = S_EVAL;
            end
            S_EVAL: begin
                if (bus.data_in == w_opp) begin
                    w_count = r_count + 3'd1;
                    w_state = S_STEP;
                end else begin
                    w_valid = (bus.data_in == w_own) && (r_count != 3'd0);
                    w_state = S_DONE;
                end
            end
            S_DONE: begin
                w_done  = 1'b1;
                w_ctrl  = 1'b0;
                if (!r_valid) begin
                    w_count = 3'd0;
                end
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign bus.addr_out = r_addr;
    assign bus.ctrl_mem = r_ctrl;
    assign bus.done     = r_done;
    assign bus.valid    = r_valid;
    assign bus.count    = r_count;
    assign bus.step_o   = r_step;

endmodule

`default_nettype wire
